// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder controller.
package byte_serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte index width; a single-byte build still carries a 1-bit index.
    function automatic int idx_width(input int nbytes);
        int w;
        if (nbytes <= 1) begin
            w = 1;
        end else begin
            w = $clog2(nbytes);
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_adder_slice.sv
// One 8-bit ripple-carry adder slice shared across all bytes of an operation.
module byte_adder_slice
    import byte_serial_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] sum,
    output logic              co
);

    logic [BYTE_W:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign co = carry_s[BYTE_W];

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Wide add/subtract sequenced through one 8-bit slice, LSB byte first,
// with valid/ready handshakes on both the operand and result sides.
module byte_serial_adder_ctrl
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic                     op_sub,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     ci,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     co,
    output logic                     ovf
);

    localparam int W      = BYTE_W * NBYTES;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam int BASE_W = IDX_W + 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [W-1:0]      opa_r;
    logic [W-1:0]      opb_r;
    logic [W-1:0]      sum_r;
    logic              carry_r;
    logic              co_r;
    logic              ovf_r;
    logic              start_ready_r;
    logic              res_valid_r;
    logic [IDX_W-1:0]  idx_r;
    logic [BASE_W-1:0] base_s;
    logic [BYTE_W-1:0] slice_a_s;
    logic [BYTE_W-1:0] slice_b_s;
    logic [BYTE_W-1:0] slice_sum_s;
    logic              slice_co_s;
    logic              last_s;

    // Operand byte select for the current index (byte offset = idx * 8).
    always_comb begin
        base_s    = {idx_r, 3'b000};
        slice_a_s = opa_r[base_s +: BYTE_W];
        slice_b_s = opb_r[base_s +: BYTE_W];
        last_s    = (idx_r == LAST_IDX);
    end

    byte_adder_slice u_slice (
        .a   (slice_a_s),
        .b   (slice_b_s),
        .ci  (carry_r),
        .sum (slice_sum_s),
        .co  (slice_co_s)
    );

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            res_valid_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            start_ready_r <= (state_next_s == IDLE);
            res_valid_r   <= (state_next_s == DONE);
        end
    end

    // Operand capture, byte-serial accumulation and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r   <= {W{1'b0}};
            opb_r   <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        // Subtract is A + ~B + 1, so the carry seeds the +1.
                        opa_r   <= a;
                        opb_r   <= op_sub ? ~b : b;
                        carry_r <= op_sub ? 1'b1 : ci;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    sum_r[base_s +: BYTE_W] <= slice_sum_s;
                    carry_r                 <= slice_co_s;
                    if (last_s) begin
                        co_r  <= slice_co_s;
                        ovf_r <= (opa_r[W-1] == opb_r[W-1]) &&
                                 (slice_sum_s[BYTE_W-1] != opa_r[W-1]);
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = start_ready_r;
    assign res_valid   = res_valid_r;
    assign sum         = sum_r;
    assign co          = co_r;
    assign ovf         = ovf_r;

endmodule
